alu_seq_mdu: RTL and testbench
==============================

// Module: alu_seq_mdu
// PURPOSE
//  Parametrised, handshaked successor to the single-cycle R-type ALU. Executes base integer ops
//  with 1-cycle registered latency and RV-M multiply/divide ops with an iterative fixed latency.
//  Sits between decode/register-read and writeback in the multi-cycle datapath. Stalls upstream via in_ready.
// PARAMETERS
//  XLEN    32  operand/result width; must be >= 8 and a power of two; shamt = operand2[$clog2(XLEN)-1:0]
//  MDU_EN  1   1: M-extension ops implemented; 0: M ops are flagged illegal
// PORTS
//  clk           in   1     single clock, rising edge
//  rst_n         in   1     asynchronous, active-low reset
//  in_valid      in   1     request valid
//  in_ready      out  1     block can accept a request this cycle
//  operand1      in   XLEN  rs1 value
//  operand2      in   XLEN  rs2 value
//  ALUoperation  in   5     op code (see BEHAVIOUR)
//  out_valid     out  1     result/zero/illegal valid
//  out_ready     in   1     downstream accepts result
//  result        out  XLEN  result
//  zero          out  1     result == 0
//  illegal       out  1     unsupported op code; result forced to 0
// BEHAVIOUR
//  Ops: 00 ADD 01 SUB 02 AND 03 OR 04 XOR 05 SLL 06 SRL 07 SRA 08 SLT 09 SLTU (base);
//   0A MUL 0B MULH 0C MULHSU 0D MULHU 0E DIV 0F DIVU 10 REM 11 REMU (M); 12..1F illegal.
//  Reset (async, rst_n=0): state IDLE; in_ready=0 while rst_n=0, 1 from first edge after deassert;
//   out_valid=0, result=0, zero=0, illegal=0; any in-flight op discarded, no output produced.
//  FSM: IDLE -> accept (in_valid&in_ready) -> base/illegal op: DONE; M op: BUSY.
//   BUSY: counter counts XLEN iterations (1 bit/cycle shift-add mult, restoring div), then FIX cycle.
//   FIX: sign correction / special cases, -> DONE. DONE: out_valid=1; on out_ready -> IDLE.
//  in_ready = (state==IDLE). No accept in BUSY/FIX/DONE; single request in flight (no pipelining).
//  Latency (accept edge = N): base/illegal: out_valid from edge N+1; M ops: from edge N+XLEN+2. Fixed;
//   no early-out for zero operands or special cases.
//  Outputs held stable while out_valid=1 and out_ready=0. out_ready ignored when out_valid=0.
//  Operands and op code captured at accept; later changes on inputs have no effect.
//  Arithmetic: ADD/SUB/MUL wrap modulo 2^XLEN. SLT/SLTU return 1 or 0. SRA sign-fills.
//  MULH signed x signed, MULHSU signed rs1 x unsigned rs2, MULHU unsigned; return upper XLEN bits.
//  DIV/REM round toward zero; remainder takes sign of dividend.
//  Divide by zero: DIV/DIVU -> all ones; REM/REMU -> operand1. No exception flag.
//  Signed overflow (operand1 = -2^(XLEN-1), operand2 = -1): DIV -> operand1, REM -> 0.
//  MDU_EN=0: ops 0A..11 behave as illegal (latency 1, result 0, illegal=1).
//  zero computed from final result in same cycle out_valid rises; illegal implies zero=1.
//  Reset mid-BUSY: FSM to IDLE immediately (async); no stale out_valid after reset release.
// TESTING
//  1 Reset: rst_n low mid-DIV -> out_valid=0, result=0 at once; after release in_ready=1 next edge.
//  2 ADD 7+(-7), out_ready=1 -> out_valid at N+1, result=0, zero=1; SRA 0x80000000>>>4 -> 0xF8000000.
//  3 MULH 0xFFFFFFFF*0xFFFFFFFF -> 0 at N+34; MULHU same -> 0xFFFFFFFE; MUL 0x10000*0x10000 -> 0, zero=1.
//  4 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
//  5 DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, zero=1; op 0x15 -> illegal=1, result 0 at N+1.
//  6 Backpressure: out_ready=0 for 5 cycles -> result held, in_ready=0, in_valid pulses ignored;
//   out_ready=1 -> IDLE next edge, back-to-back request accepted; repeat all with XLEN=64, MDU_EN=0.

Source files
------------

// File: rtl/alu_seq_mdu.sv
// Handshaked integer ALU with a 1-bit-per-cycle multiply/divide unit (RV-M).
// One request in flight; base ops complete in one cycle, M ops in XLEN+2 cycles.
module alu_seq_mdu #(
  parameter int unsigned XLEN   = 32,
  parameter bit          MDU_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  input  logic [4:0]      ALUoperation,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int unsigned SW = $clog2(XLEN);

  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_BUSY, S_FIX, S_DONE} state_t;

  typedef enum logic [4:0] {
    OP_ADD = 5'h00, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_t;

  state_t              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                zero_q, zero_d;
  logic                illegal_q, illegal_d;
  logic [4:0]          op_q, op_d;
  logic [XLEN-1:0]     opa_q, opa_d;
  logic [XLEN-1:0]     opb_q, opb_d;
  logic [2*XLEN:0]     acc_q, acc_d;
  logic [SW-1:0]       cnt_q, cnt_d;
  logic                neg_q, neg_d;

  logic                is_m, is_rem, op_illegal, sgn_a, sgn_b, a_neg, b_neg;
  logic [XLEN-1:0]     base_res, a_mag, b_mag, mul_res, div_res, quo, rem;
  logic [XLEN:0]       mul_sum, rem_sh, trial;
  logic [2*XLEN:0]     acc_add;
  logic [2*XLEN-1:0]   prod, prod_s;

  always_comb begin
    is_m       = (op_q >= OP_MUL) && (op_q <= OP_REMU);
    is_rem     = (op_q == OP_REM) || (op_q == OP_REMU);
    op_illegal = (op_q > OP_REMU) || (is_m && !MDU_EN);
    sgn_a      = op_q inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    sgn_b      = op_q inside {OP_MULH, OP_DIV, OP_REM};
    a_neg      = sgn_a && opa_q[XLEN-1];
    b_neg      = sgn_b && opb_q[XLEN-1];
    a_mag      = a_neg ? -opa_q : opa_q;
    b_mag      = b_neg ? -opb_q : opb_q;
  end

  always_comb begin
    base_res = '0;
    case (op_q)
      OP_ADD:  base_res = opa_q + opb_q;
      OP_SUB:  base_res = opa_q - opb_q;
      OP_AND:  base_res = opa_q & opb_q;
      OP_OR:   base_res = opa_q | opb_q;
      OP_XOR:  base_res = opa_q ^ opb_q;
      OP_SLL:  base_res = opa_q << opb_q[SW-1:0];
      OP_SRL:  base_res = opa_q >> opb_q[SW-1:0];
      OP_SRA:  base_res = $unsigned($signed(opa_q) >>> opb_q[SW-1:0]);
      OP_SLT:  base_res[0] = $signed(opa_q) < $signed(opb_q);
      OP_SLTU: base_res[0] = opa_q < opb_q;
      default: base_res = '0;
    endcase
  end

  // Iteration datapath: acc holds {hi, lo} of the product, or {remainder, quotient}.
  always_comb begin
    mul_sum = acc_q[2*XLEN:XLEN] + {1'b0, opb_q};
    acc_add = acc_q[0] ? {mul_sum, acc_q[XLEN-1:0]} : acc_q;
    rem_sh  = acc_q[2*XLEN-1:XLEN-1];
    trial   = rem_sh - {1'b0, opb_q};
    prod    = acc_q[2*XLEN-1:0];
    prod_s  = neg_q ? -prod : prod;
    mul_res = (op_q == OP_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    quo     = acc_q[XLEN-1:0];
    rem     = acc_q[2*XLEN-1:XLEN];
    if (opb_q == '0) begin
      div_res = is_rem ? opa_q : '1;
    end else if (is_rem) begin
      div_res = neg_q ? -rem : rem;
    end else begin
      div_res = neg_q ? -quo : quo;
    end
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    op_d        = op_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          op_d    = ALUoperation;
          opa_d   = operand1;
          opb_d   = operand2;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (op_illegal) begin
          result_d    = '0;
          zero_d      = 1'b1;
          illegal_d   = 1'b1;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else if (!is_m) begin
          result_d    = base_res;
          zero_d      = (base_res == '0);
          illegal_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          // Iterate on magnitudes; opa keeps the raw dividend for REM-by-zero.
          opb_d   = b_mag;
          acc_d   = {{(XLEN+1){1'b0}}, a_mag};
          neg_d   = is_rem ? a_neg : (a_neg ^ b_neg);
          cnt_d   = '1;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (op_q >= OP_DIV) begin
          acc_d = trial[XLEN] ? {acc_q[2*XLEN-1:0], 1'b0}
                              : {trial, acc_q[XLEN-2:0], 1'b1};
        end else begin
          acc_d = acc_add >> 1;
        end
        cnt_d = cnt_q - SW'(1);
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        result_d    = (op_q >= OP_DIV) ? div_res : mul_res;
        zero_d      = (((op_q >= OP_DIV) ? div_res : mul_res) == '0);
        illegal_d   = 1'b0;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      op_q        <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
      op_q        <= op_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_seq_mdu.sv
// Bench for alu_seq_mdu: a 32-bit M-enabled instance and a 64-bit MDU_EN=0 instance,
// driven one at a time and compared against a wide-arithmetic reference model.
module tb_alu_seq_mdu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready, sel;
  logic [63:0] op1, op2;
  logic [4:0]  aop;

  logic        rdy32, ov32, z32, il32;
  logic [31:0] res32;
  logic        rdy64, ov64, z64, il64;
  logic [63:0] res64;

  logic        rdy, ovalid, zf, ilf;
  logic [63:0] res;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_seq_mdu #(.XLEN(32), .MDU_EN(1'b1)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & ~sel), .in_ready(rdy32),
    .operand1(op1[31:0]), .operand2(op2[31:0]), .ALUoperation(aop),
    .out_valid(ov32), .out_ready(out_ready), .result(res32), .zero(z32), .illegal(il32)
  );

  alu_seq_mdu #(.XLEN(64), .MDU_EN(1'b0)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & sel), .in_ready(rdy64),
    .operand1(op1), .operand2(op2), .ALUoperation(aop),
    .out_valid(ov64), .out_ready(out_ready), .result(res64), .zero(z64), .illegal(il64)
  );

  assign rdy    = sel ? rdy64 : rdy32;
  assign ovalid = sel ? ov64  : ov32;
  assign zf     = sel ? z64   : z32;
  assign ilf    = sel ? il64  : il32;
  assign res    = sel ? res64 : {32'h0, res32};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: RV semantics evaluated in 128-bit signed arithmetic, then truncated to xl bits.
  function automatic logic [63:0] ref_alu(input int xl, input bit mdu, input logic [4:0] op,
                                          input logic [63:0] a, input logic [63:0] b,
                                          output bit ill, output int lat);
    logic [63:0]          mask;
    logic signed [127:0]  sa, sb, ua, ub, t, smin;
    int                   sh;
    mask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    ua   = {64'h0, a & mask};
    ub   = {64'h0, b & mask};
    sa   = (xl == 64) ? {{64{a[63]}}, a} : {{96{a[31]}}, a[31:0]};
    sb   = (xl == 64) ? {{64{b[63]}}, b} : {{96{b[31]}}, b[31:0]};
    smin = -(128'sd1 <<< (xl - 1));
    sh   = int'(b[5:0]) & (xl - 1);
    ill  = (op > 5'h11) || (!mdu && op >= 5'h0A);
    lat  = (ill || op < 5'h0A) ? 1 : xl + 2;
    t    = '0;
    if (!ill) begin
      case (op)
        5'h00: t = sa + sb;
        5'h01: t = sa - sb;
        5'h02: t = ua & ub;
        5'h03: t = ua | ub;
        5'h04: t = ua ^ ub;
        5'h05: t = ua << sh;
        5'h06: t = ua >> sh;
        5'h07: t = sa >>> sh;
        5'h08: t = (sa < sb) ? 128'sd1 : 128'sd0;
        5'h09: t = (ua < ub) ? 128'sd1 : 128'sd0;
        5'h0A: t = sa * sb;
        5'h0B: t = (sa * sb) >>> xl;
        5'h0C: t = (sa * ub) >>> xl;
        5'h0D: t = (ua * ub) >>> xl;
        5'h0E: t = (ub == 0) ? -128'sd1 : ((sa == smin && sb == -1) ? sa : sa / sb);
        5'h0F: t = (ub == 0) ? -128'sd1 : ua / ub;
        5'h10: t = (ub == 0) ? sa : ((sa == smin && sb == -1) ? 128'sd0 : sa % sb);
        5'h11: t = (ub == 0) ? ua : ua % ub;
        default: t = '0;
      endcase
    end
    return t[63:0] & mask;
  endfunction

  function automatic logic [63:0] rnd_opnd(input int xl);
    case ($urandom_range(0, 5))
      0: return 64'h0;
      1: return 64'h1;
      2: return 64'hFFFF_FFFF_FFFF_FFFF;
      3: return (xl == 64) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
      4: return 64'($urandom_range(0, 70));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic run_op(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                        input int hold);
    int          xl, lat, cyc;
    bit          ill;
    logic [63:0] exp, held;
    xl  = sel ? 64 : 32;
    exp = ref_alu(xl, ~sel, op, a, b, ill, lat);
    @(negedge clk);
    cyc = 0;
    while (!rdy && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("in_ready_idle", 64'(rdy), 64'd1);
    in_valid  = 1'b1;
    aop       = op;
    op1       = a;
    op2       = b;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op1      = {$urandom, $urandom};
    op2      = {$urandom, $urandom};
    aop      = 5'($urandom);
    cyc      = 0;
    while (!ovalid && cyc < xl + 8) begin
      check_eq("in_ready_busy", 64'(rdy), 64'd0);
      in_valid = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq($sformatf("latency op%0h", op), 64'(cyc), 64'(lat));
    check_eq($sformatf("result op%0h a=%h b=%h", op, a, b), res, exp);
    check_eq($sformatf("zero op%0h", op), 64'(zf), 64'(exp == 64'h0 || ill));
    check_eq($sformatf("illegal op%0h", op), 64'(ilf), 64'(ill));
    held = res;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check_eq("held_result", res, held);
      check_eq("held_valid", 64'(ovalid), 64'd1);
      check_eq("held_in_ready", 64'(rdy), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("released_valid", 64'(ovalid), 64'd0);
    check_eq("released_in_ready", 64'(rdy), 64'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel = 1'b0;
    op1 = '0; op2 = '0; aop = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      check_eq("rst_in_ready", 64'(rdy), 64'd0);
      check_eq("rst_out_valid", 64'(ovalid), 64'd0);
      check_eq("rst_result", res, 64'd0);
      check_eq("rst_zero", 64'(zf), 64'd0);
      check_eq("rst_illegal", 64'(ilf), 64'd0);
    end
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("in_ready_after_release", 64'(rdy), 64'd1);

    // 32-bit, M-extension enabled
    run_op(5'h00, 64'h7, 64'hFFFF_FFF9, 0);
    run_op(5'h07, 64'h8000_0000, 64'h4, 2);
    run_op(5'h0B, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 0);
    run_op(5'h0D, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1);
    run_op(5'h0A, 64'h1_0000, 64'h1_0000, 0);
    run_op(5'h0E, 64'hFFFF_FFF9, 64'h2, 0);
    run_op(5'h10, 64'hFFFF_FFF9, 64'h2, 0);
    run_op(5'h0F, 64'h5, 64'h0, 0);
    run_op(5'h11, 64'h5, 64'h0, 0);
    run_op(5'h0E, 64'h8000_0000, 64'hFFFF_FFFF, 0);
    run_op(5'h10, 64'h8000_0000, 64'hFFFF_FFFF, 0);
    run_op(5'h15, 64'h1234, 64'h5678, 5);
    run_op(5'h0C, 64'hFFFF_FFFE, 64'h3, 5);
    for (int i = 0; i < 60; i++) begin
      run_op(5'($urandom_range(0, 31)), rnd_opnd(32), rnd_opnd(32), $urandom_range(0, 3));
    end

    // Reset while a divide is iterating
    @(negedge clk);
    in_valid = 1'b1; aop = 5'h0E; op1 = 64'h1234_5678; op2 = 64'h7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("midreset_valid", 64'(ovalid), 64'd0);
    check_eq("midreset_result", res, 64'd0);
    check_eq("midreset_in_ready", 64'(rdy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midreset_release_ready", 64'(rdy), 64'd1);
    repeat (40) @(posedge clk);
    #1;
    check_eq("midreset_no_stale", 64'(ovalid), 64'd0);

    // 64-bit, M-extension disabled
    sel = 1'b1;
    run_op(5'h00, 64'h7, 64'hFFFF_FFFF_FFFF_FFF9, 0);
    run_op(5'h07, 64'h8000_0000_0000_0000, 64'h4, 3);
    run_op(5'h05, 64'h1, 64'h3F, 0);
    run_op(5'h0B, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_op(5'h0E, 64'h7, 64'h2, 5);
    run_op(5'h15, 64'h1, 64'h1, 0);
    for (int i = 0; i < 40; i++) begin
      run_op(5'($urandom_range(0, 31)), rnd_opnd(64), rnd_opnd(64), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
